c2_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared C2 memory bus. It sits between NUM_REQ line-level requesters (cache controllers, prefetcher) and the `Memory` model. It grants the bus to one requester at a time and drives the C2 command, address and data beats for whole-line reads and writes. For reads it also collects the response beats into a line buffer. Memory-side outputs are split into value plus output-enable; the top level builds the tri-state `cmd_w`/`data_w` wires from them.

---
 rtl/c2_bus_arbiter_if.sv | 32 +++
 rtl/c2_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_c2_bus_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/c2_bus_arbiter_if.sv
// c2_bus_arbiter_if
// Memory-side signals of the C2 bus as seen by the arbiter.
// The arbiter drives the split value/output-enable pairs. The top level
// resolves them into the tri-state cmd_w/data_w wires and feeds the
// resolved values back through m_cmd_in/m_data_in.
//   m_addr      line address to memory
//   m_cmd_out   C2 command value      m_cmd_oe   drive enable for cmd_w
//   m_data_out  write beat value      m_data_oe  drive enable for data_w
//   m_cmd_in    resolved cmd_w        m_data_in  resolved data_w
// Modports: master = arbiter side, slave = memory / bus-resolution side.
interface c2_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] m_addr;
    logic [1:0]        m_cmd_out;
    logic              m_cmd_oe;
    logic [DATA_W-1:0] m_data_out;
    logic              m_data_oe;
    logic [1:0]        m_cmd_in;
    logic [DATA_W-1:0] m_data_in;

    modport master (
        output m_addr, m_cmd_out, m_cmd_oe, m_data_out, m_data_oe,
        input  m_cmd_in, m_data_in
    );

    modport slave (
        input  m_addr, m_cmd_out, m_cmd_oe, m_data_out, m_data_oe,
        output m_cmd_in, m_data_in
    );
endinterface

// File: rtl/c2_bus_arbiter.sv
// c2_bus_arbiter
// Round-robin arbiter and line sequencer for the shared C2 memory bus.
// It grants one requester at a time and runs a whole-line read or write.
// Read beats are collected into rsp_line.
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   req_valid/req_write     per-requester request and direction (1 = write)
//   req_addr/req_wline      per-requester line address and write line
//   grant                   one-hot owner
//   done                    one-cycle completion pulse to the owner
//   err                     one-cycle read-timeout pulse
//   rsp_line                collected read line, valid while done is high
//   bus                     memory-side C2 signals (master modport)
// Optional feature: define C2_ARB_TIMEOUT_EN to enable the read-response
// watchdog (TIMEOUT cycles in RD_WAIT). Without it err is tied low.
//
// state   | meaning
// IDLE    | waiting for a request, round-robin pick
// RD_CMD  | driving READ_LINE + address for one cycle
// RD_WAIT | bus released, waiting for RESPONSE
// RD_DATA | sampling BEATS response beats
// WR_DATA | driving WRITE_LINE + BEATS data beats
// WR_NOP  | one NOP cycle closing the write
// DONE    | done pulse to owner, grant clears on exit
module c2_bus_arbiter #(
    parameter  int NUM_REQ = 2,
    parameter  int ADDR_W  = 16,
    parameter  int DATA_W  = 8,
    parameter  int BEATS   = 8,
    parameter  int TIMEOUT = 64,
    localparam int LINE_W  = DATA_W * BEATS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LINE_W-1:0]   req_wline,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic                        err,
    output logic [LINE_W-1:0]           rsp_line,
    c2_bus_arbiter_if.master            bus
);
    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_READ_LINE  = 2'd1;
    localparam logic [1:0] C2_WRITE_LINE = 2'd2;
    localparam logic [1:0] C2_RESPONSE   = 2'd3;

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("c2_bus_arbiter: NUM_REQ must be 2..8");
    end
    if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_beats
        $error("c2_bus_arbiter: BEATS must be a power of two >= 2");
    end
    if (TIMEOUT < 1 || TMO_W < 1) begin : g_bad_timeout
        $error("c2_bus_arbiter: TIMEOUT must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE, RD_CMD, RD_WAIT, RD_DATA, WR_DATA, WR_NOP, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   rsp_line_q, rsp_line_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [1:0]          m_cmd_out_q, m_cmd_out_d;
    logic                m_cmd_oe_q, m_cmd_oe_d;
    logic [DATA_W-1:0]   m_data_out_q, m_data_out_d;
    logic                m_data_oe_q, m_data_oe_d;
`ifdef C2_ARB_TIMEOUT_EN
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;
`endif

    logic [IDX_W-1:0]    pick;
    logic [BEAT_W-1:0]   beat_inc;
    int                  cand;

    always_comb begin
        // Scan downward so the nearest set bit after `last` wins; the
        // j == NUM_REQ term lets the previous owner win when it is alone.
        pick = last_q;
        cand = 0;
        for (int j = NUM_REQ; j >= 1; j--) begin
            cand = int'(last_q) + j;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (req_valid[cand]) pick = IDX_W'(cand);
        end
        beat_inc = beat_q + 1'b1;

        state_d      = state_q;
        grant_d      = grant_q;
        done_d       = '0;
        owner_d      = owner_q;
        last_d       = last_q;
        wline_d      = wline_q;
        rsp_line_d   = rsp_line_q;
        beat_d       = beat_q;
        m_addr_d     = m_addr_q;
        m_cmd_out_d  = m_cmd_out_q;
        m_cmd_oe_d   = m_cmd_oe_q;
        m_data_out_d = m_data_out_q;
        m_data_oe_d  = m_data_oe_q;
`ifdef C2_ARB_TIMEOUT_EN
        tmo_d        = tmo_q;
        err_d        = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    owner_d  = pick;
                    grant_d  = NUM_REQ'(1) << pick;
                    m_addr_d = req_addr[pick*ADDR_W +: ADDR_W];
                    wline_d  = req_wline[pick*LINE_W +: LINE_W];
                    beat_d   = '0;
                    m_cmd_oe_d = 1'b1;
                    if (req_write[pick]) begin
                        state_d      = WR_DATA;
                        m_cmd_out_d  = C2_WRITE_LINE;
                        m_data_oe_d  = 1'b1;
                        m_data_out_d = req_wline[pick*LINE_W +: DATA_W];
                    end else begin
                        state_d     = RD_CMD;
                        m_cmd_out_d = C2_READ_LINE;
                        m_data_oe_d = 1'b0;
                        // Cleared here so a timed-out read reports zeros.
                        rsp_line_d  = '0;
                    end
                end
            end
            RD_CMD: begin
                state_d     = RD_WAIT;
                m_cmd_oe_d  = 1'b0;
                m_cmd_out_d = C2_NOP;
`ifdef C2_ARB_TIMEOUT_EN
                tmo_d = TMO_W'(TIMEOUT - 1);
`endif
            end
            RD_WAIT: begin
                if (bus.m_cmd_in == C2_RESPONSE) begin
                    state_d = RD_DATA;
                    beat_d  = '0;
                end
`ifdef C2_ARB_TIMEOUT_EN
                else if (tmo_q == '0) begin
                    state_d = DONE;
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    last_d  = owner_q;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
`endif
            end
            RD_DATA: begin
                rsp_line_d[beat_q*DATA_W +: DATA_W] = bus.m_data_in;
                beat_d = beat_inc;
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d = DONE;
                    done_d  = grant_q;
                    last_d  = owner_q;
                end
            end
            WR_DATA: begin
                beat_d = beat_inc;
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    state_d      = WR_NOP;
                    m_cmd_out_d  = C2_NOP;
                    m_data_oe_d  = 1'b0;
                    m_data_out_d = '0;
                end else begin
                    m_data_out_d = wline_q[beat_inc*DATA_W +: DATA_W];
                end
            end
            WR_NOP: begin
                state_d    = DONE;
                m_cmd_oe_d = 1'b0;
                done_d     = grant_q;
                last_d     = owner_q;
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                m_cmd_oe_d = 1'b0;
                m_data_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            done_q       <= '0;
            owner_q      <= '0;
            last_q       <= IDX_W'(NUM_REQ - 1);
            wline_q      <= '0;
            rsp_line_q   <= '0;
            beat_q       <= '0;
            m_addr_q     <= '0;
            m_cmd_out_q  <= C2_NOP;
            m_cmd_oe_q   <= 1'b0;
            m_data_out_q <= '0;
            m_data_oe_q  <= 1'b0;
`ifdef C2_ARB_TIMEOUT_EN
            tmo_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            wline_q      <= wline_d;
            rsp_line_q   <= rsp_line_d;
            beat_q       <= beat_d;
            m_addr_q     <= m_addr_d;
            m_cmd_out_q  <= m_cmd_out_d;
            m_cmd_oe_q   <= m_cmd_oe_d;
            m_data_out_q <= m_data_out_d;
            m_data_oe_q  <= m_data_oe_d;
`ifdef C2_ARB_TIMEOUT_EN
            tmo_q        <= tmo_d;
            err_q        <= err_d;
`endif
        end
    end

    assign grant          = grant_q;
    assign done           = done_q;
    assign rsp_line       = rsp_line_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.m_cmd_out  = m_cmd_out_q;
    assign bus.m_cmd_oe   = m_cmd_oe_q;
    assign bus.m_data_out = m_data_out_q;
    assign bus.m_data_oe  = m_data_oe_q;
`ifdef C2_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_c2_bus_arbiter.sv
// tb_c2_bus_arbiter
// Directed bench for c2_bus_arbiter with NUM_REQ=2, 8-bit beats, BEATS=8.
// The bench plays the memory side by driving m_cmd_in/m_data_in directly.
module tb_c2_bus_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 8;
    localparam int BEATS   = 8;
    localparam int TIMEOUT = 16;
    localparam int LINE_W  = DATA_W * BEATS;

    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] RDL  = 2'd1;
    localparam logic [1:0] WRL  = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LINE_W-1:0] req_wline;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic                      err;
    logic [LINE_W-1:0]         rsp_line;

    int total = 0;
    int bad   = 0;

    c2_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    c2_bus_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .BEATS(BEATS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wline(req_wline),
        .grant(grant), .done(done), .err(err), .rsp_line(rsp_line),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = '0;
        req_write     = '0;
        req_addr      = '0;
        req_wline     = '0;
        bus.m_cmd_in  = NOP;
        bus.m_data_in = '0;
        step();
        step();

        // Reset values
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_rsp", rsp_line, 64'h0);
        chk("rst_cmd", 64'(bus.m_cmd_out), 64'(NOP));
        chk("rst_cmd_oe", 64'(bus.m_cmd_oe), 64'h0);
        chk("rst_data_oe", 64'(bus.m_data_oe), 64'h0);
        chk("rst_addr", 64'(bus.m_addr), 64'h0);
        reset = 1'b0;
        step();

        // Single read: r0, addr 3, beats 0x11..0x18
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr[0 +: ADDR_W] = 16'd3;
        step();
        chk("rd_grant", 64'(grant), 64'h1);
        chk("rd_cmd", 64'(bus.m_cmd_out), 64'(RDL));
        chk("rd_cmd_oe", 64'(bus.m_cmd_oe), 64'h1);
        chk("rd_addr", 64'(bus.m_addr), 64'h3);
        chk("rd_data_oe", 64'(bus.m_data_oe), 64'h0);
        step();
        chk("rd_wait_oe", 64'(bus.m_cmd_oe), 64'h0);
        step();
        step();
        chk("rd_wait_done", 64'(done), 64'h0);
        bus.m_cmd_in = RESP;
        step();
        bus.m_cmd_in = NOP;
        for (int k = 0; k < BEATS; k++) begin
            bus.m_data_in = 8'h11 + 8'(k);
            step();
        end
        chk("rd_done", 64'(done), 64'h1);
        chk("rd_line", rsp_line, 64'h1817161514131211);
        chk("rd_done_oe", 64'(bus.m_cmd_oe), 64'h0);
        req_valid = '0;
        step();
        chk("rd_done_pulse", 64'(done), 64'h0);
        chk("rd_grant_clr", 64'(grant), 64'h0);

        // Single write: r1, addr 5, beat k = k+1
        req_valid = 2'b10;
        req_write = 2'b10;
        req_addr[ADDR_W +: ADDR_W] = 16'd5;
        req_wline[LINE_W +: LINE_W] = 64'h0807060504030201;
        step();
        for (int k = 0; k < BEATS; k++) begin
            chk("wr_grant", 64'(grant), 64'h2);
            chk("wr_cmd", 64'(bus.m_cmd_out), 64'(WRL));
            chk("wr_cmd_oe", 64'(bus.m_cmd_oe), 64'h1);
            chk("wr_data_oe", 64'(bus.m_data_oe), 64'h1);
            chk("wr_beat", 64'(bus.m_data_out), 64'(k + 1));
            chk("wr_addr", 64'(bus.m_addr), 64'h5);
            step();
        end
        chk("wr_nop_cmd", 64'(bus.m_cmd_out), 64'(NOP));
        chk("wr_nop_data_oe", 64'(bus.m_data_oe), 64'h0);
        chk("wr_nop_done", 64'(done), 64'h0);
        step();
        chk("wr_done", 64'(done), 64'h2);
        chk("wr_done_oe", 64'(bus.m_cmd_oe), 64'h0);
        req_valid = '0;
        step();

        // Contention: both write, last = r1, so r0 first then alternation
        req_valid = 2'b11;
        req_write = 2'b11;
        req_wline[0 +: LINE_W] = 64'h0807060504030201;
        step();
        for (int n = 0; n < 4; n++) begin
            logic [1:0] eg;
            eg = (n % 2 == 0) ? 2'b01 : 2'b10;
            chk("cont_grant", 64'(grant), 64'(eg));
            repeat (9) step();
            chk("cont_done", 64'(done), 64'(eg));
            if (n == 3) req_valid = '0;
            step();
            chk("cont_idle", 64'(grant), 64'h0);
            step();
        end
        chk("cont_quiet", 64'(grant), 64'h0);

        // Reset mid-write at beat 4 (r0 again since last = r1)
        req_valid = 2'b01;
        req_write = 2'b01;
        step();
        repeat (4) step();
        chk("mid_beat4", 64'(bus.m_data_out), 64'h5);
        reset = 1'b1;
        #1;
        chk("mid_cmd_oe", 64'(bus.m_cmd_oe), 64'h0);
        chk("mid_data_oe", 64'(bus.m_data_oe), 64'h0);
        chk("mid_grant", 64'(grant), 64'h0);
        chk("mid_done", 64'(done), 64'h0);
        req_valid = '0;
        step();
        reset = 1'b0;
        step();
        chk("mid_idle_grant", 64'(grant), 64'h0);
        chk("mid_idle_done", 64'(done), 64'h0);

        // Fresh read by r1, addr 9, requester drops valid in RD_WAIT
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr[ADDR_W +: ADDR_W] = 16'd9;
        step();
        chk("drop_grant", 64'(grant), 64'h2);
        chk("drop_addr", 64'(bus.m_addr), 64'h9);
        step();
        req_valid = '0;
        repeat (3) step();
        chk("drop_wait", 64'(done), 64'h0);
        chk("drop_held", 64'(grant), 64'h2);
        bus.m_cmd_in = RESP;
        step();
        bus.m_cmd_in = NOP;
        for (int k = 0; k < BEATS; k++) begin
            bus.m_data_in = 8'hA0 + 8'(k);
            step();
        end
        chk("drop_done", 64'(done), 64'h2);
        chk("drop_line", rsp_line, 64'hA7A6A5A4A3A2A1A0);
        chk("drop_err", 64'(err), 64'h0);
        step();
        chk("drop_pulse", 64'(done), 64'h0);
        step();

        // Read with no response from memory (r0)
        req_valid = 2'b01;
        req_write = 2'b00;
        step();
        step();
`ifdef C2_ARB_TIMEOUT_EN
        repeat (TIMEOUT - 1) step();
        chk("tmo_early_done", 64'(done), 64'h0);
        chk("tmo_early_err", 64'(err), 64'h0);
        step();
        chk("tmo_err", 64'(err), 64'h1);
        chk("tmo_done", 64'(done), 64'h1);
        chk("tmo_line", rsp_line, 64'h0);
        req_valid = '0;
        step();
        chk("tmo_err_pulse", 64'(err), 64'h0);
        chk("tmo_grant_clr", 64'(grant), 64'h0);
`else
        repeat (TIMEOUT + 4) step();
        chk("nowd_done", 64'(done), 64'h0);
        chk("nowd_err", 64'(err), 64'h0);
        chk("nowd_grant", 64'(grant), 64'h1);
        req_valid = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("nowd_rst_grant", 64'(grant), 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
